// File: rtl/udp_rx_strip.sv
// UDP receive stage: parses and strips the 8-byte UDP header, filters on destination port and
// checks payload length against the header. Define UDP_RX_STATS_EN to build the frame counters.
module udp_rx_strip #(
  parameter int          DATA_BYTES  = 1,
  parameter logic [15:0] LISTEN_PORT = 16'h0000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [8*DATA_BYTES-1:0] s_tdata,
  input  logic [DATA_BYTES-1:0]   s_tkeep,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic [8*DATA_BYTES-1:0] m_tdata,
  output logic [DATA_BYTES-1:0]   m_tkeep,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  output logic                    m_tuser,
  input  logic                    m_tready,
  output logic [15:0]             src_port_out,
  output logic [15:0]             dest_port_out,
  output logic [15:0]             length_out,
  output logic                    hdr_valid_out,
  output logic [31:0]             stat_ok_out,
  output logic [31:0]             stat_drop_out,
  output logic [31:0]             stat_err_out
);

  localparam int HDR_BEATS = 8 / DATA_BYTES;
  localparam int CNT_W     = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
  localparam int POP_W     = $clog2(DATA_BYTES + 1);

  typedef enum logic [1:0] {ST_HDR, ST_PAYLOAD, ST_DROP} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        hdr_cnt_q, hdr_cnt_d;
  logic [7:0][7:0]         hdr_q, hdr_d;          // byte 0 is the first byte on the wire
  logic [15:0]             expected_q, expected_d;
  logic [15:0]             payload_cnt_q, payload_cnt_d;
  logic [8*DATA_BYTES-1:0] m_tdata_q, m_tdata_d;
  logic [DATA_BYTES-1:0]   m_tkeep_q, m_tkeep_d;
  logic                    m_tvalid_q, m_tvalid_d;
  logic                    m_tlast_q, m_tlast_d;
  logic                    m_tuser_q, m_tuser_d;
  logic [15:0]             src_port_q, src_port_d;
  logic [15:0]             dest_port_q, dest_port_d;
  logic [15:0]             length_q, length_d;
  logic                    hdr_valid_q, hdr_valid_d;

  logic                    ready_w;
  logic                    beat_fire;
  logic                    last_hdr_beat;
  logic [POP_W-1:0]        keep_pop;
  logic [16:0]             sum_wide;
  logic [15:0]             sum_sat;
  logic                    len_err;
  logic [15:0]             f_src, f_dest, f_len;
  logic                    port_ok;

  // Reset gates ready directly so upstream sees a stalled sink for the whole reset window.
  assign s_tready      = reset_n && ready_w;
  assign beat_fire     = s_tvalid && s_tready;
  assign last_hdr_beat = (hdr_cnt_q == CNT_W'(HDR_BEATS - 1));

  assign sum_wide = {1'b0, payload_cnt_q} + 17'(keep_pop);
  assign sum_sat  = sum_wide[16] ? 16'hFFFF : sum_wide[15:0];
  assign len_err  = (sum_sat != expected_q);

  assign f_src   = {hdr_d[0], hdr_d[1]};
  assign f_dest  = {hdr_d[2], hdr_d[3]};
  assign f_len   = {hdr_d[4], hdr_d[5]};
  assign port_ok = (LISTEN_PORT == 16'h0000) || (f_dest == LISTEN_PORT);

  always_comb begin
    keep_pop = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      keep_pop = keep_pop + POP_W'(s_tkeep[i]);
    end
  end

  always_comb begin
    hdr_d = hdr_q;
    if (state_q == ST_HDR && beat_fire) begin
      for (int i = 0; i < DATA_BYTES; i++) begin
        hdr_d[3'(int'(hdr_cnt_q) * DATA_BYTES + i)] = s_tdata[8*i +: 8];
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    hdr_cnt_d     = hdr_cnt_q;
    expected_d    = expected_q;
    payload_cnt_d = payload_cnt_q;
    m_tdata_d     = m_tdata_q;
    m_tkeep_d     = m_tkeep_q;
    m_tvalid_d    = m_tvalid_q;
    m_tlast_d     = m_tlast_q;
    m_tuser_d     = m_tuser_q;
    src_port_d    = src_port_q;
    dest_port_d   = dest_port_q;
    length_d      = length_q;
    hdr_valid_d   = 1'b0;
    ready_w       = 1'b1;

    // The output register drains independently of state, so HDR can overlap the old last beat.
    if (m_tready) m_tvalid_d = 1'b0;

    unique case (state_q)
      ST_HDR: begin
        if (beat_fire) begin
          if (last_hdr_beat) begin
            hdr_cnt_d = '0;
            if (port_ok) begin
              src_port_d    = f_src;
              dest_port_d   = f_dest;
              length_d      = f_len;
              hdr_valid_d   = 1'b1;
              expected_d    = (f_len < 16'd8) ? 16'd0 : f_len - 16'd8;
              payload_cnt_d = '0;
              state_d       = s_tlast ? ST_HDR : ST_PAYLOAD;
            end else begin
              state_d = s_tlast ? ST_HDR : ST_DROP;
            end
          end else if (s_tlast) begin
            hdr_cnt_d = '0;
          end else begin
            hdr_cnt_d = hdr_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PAYLOAD: begin
        ready_w = !m_tvalid_q || m_tready;
        if (beat_fire) begin
          m_tdata_d     = s_tdata;
          m_tkeep_d     = s_tkeep;
          m_tvalid_d    = 1'b1;
          m_tlast_d     = s_tlast;
          m_tuser_d     = s_tlast && len_err;
          payload_cnt_d = sum_sat;
          if (s_tlast) state_d = ST_HDR;
        end
      end
      ST_DROP: begin
        if (beat_fire && s_tlast) state_d = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_HDR;
      hdr_cnt_q     <= '0;
      hdr_q         <= '0;
      expected_q    <= '0;
      payload_cnt_q <= '0;
      m_tdata_q     <= '0;
      m_tkeep_q     <= '0;
      m_tvalid_q    <= 1'b0;
      m_tlast_q     <= 1'b0;
      m_tuser_q     <= 1'b0;
      src_port_q    <= '0;
      dest_port_q   <= '0;
      length_q      <= '0;
      hdr_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hdr_cnt_q     <= hdr_cnt_d;
      hdr_q         <= hdr_d;
      expected_q    <= expected_d;
      payload_cnt_q <= payload_cnt_d;
      m_tdata_q     <= m_tdata_d;
      m_tkeep_q     <= m_tkeep_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tlast_q     <= m_tlast_d;
      m_tuser_q     <= m_tuser_d;
      src_port_q    <= src_port_d;
      dest_port_q   <= dest_port_d;
      length_q      <= length_d;
      hdr_valid_q   <= hdr_valid_d;
    end
  end

  assign m_tdata       = m_tdata_q;
  assign m_tkeep       = m_tkeep_q;
  assign m_tvalid      = m_tvalid_q;
  assign m_tlast       = m_tlast_q;
  assign m_tuser       = m_tuser_q;
  assign src_port_out  = src_port_q;
  assign dest_port_out = dest_port_q;
  assign length_out    = length_q;
  assign hdr_valid_out = hdr_valid_q;

`ifdef UDP_RX_STATS_EN
  logic        frame_end, ok_inc, drop_inc, err_inc;
  logic [31:0] stat_ok_q, stat_drop_q, stat_err_q;

  assign frame_end = beat_fire && s_tlast;
  assign ok_inc    = frame_end && ((state_q == ST_HDR && last_hdr_beat && port_ok) ||
                                   (state_q == ST_PAYLOAD && !len_err));
  assign drop_inc  = frame_end && ((state_q == ST_HDR && !(last_hdr_beat && port_ok)) ||
                                   (state_q == ST_DROP));
  assign err_inc   = frame_end && (state_q == ST_PAYLOAD) && len_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_ok_q   <= '0;
      stat_drop_q <= '0;
      stat_err_q  <= '0;
    end else begin
      if (ok_inc)   stat_ok_q   <= stat_ok_q + 32'd1;
      if (drop_inc) stat_drop_q <= stat_drop_q + 32'd1;
      if (err_inc)  stat_err_q  <= stat_err_q + 32'd1;
    end
  end

  assign stat_ok_out   = stat_ok_q;
  assign stat_drop_out = stat_drop_q;
  assign stat_err_out  = stat_err_q;
`else
  assign stat_ok_out   = '0;
  assign stat_drop_out = '0;
  assign stat_err_out  = '0;
`endif

endmodule

// File: tb/tb_udp_rx_strip.sv
// Directed bench for udp_rx_strip: a 1-byte/open-port instance and a 4-byte/filtered instance.
module tb_udp_rx_strip;

  typedef logic [7:0] byte_q_t [$];

`ifdef UDP_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b0;

  // Instance A: DATA_BYTES=1, accepts every port
  logic [7:0]  a_s_tdata = '0;
  logic [0:0]  a_s_tkeep = 1'b1;
  logic        a_s_tvalid = 1'b0, a_s_tlast = 1'b0, a_s_tready;
  logic [7:0]  a_m_tdata;
  logic [0:0]  a_m_tkeep;
  logic        a_m_tvalid, a_m_tlast, a_m_tuser;
  logic        a_m_tready = 1'b1;
  logic [15:0] a_src, a_dest, a_len;
  logic        a_hdr_valid;
  logic [31:0] a_st_ok, a_st_drop, a_st_err;

  // Instance B: DATA_BYTES=4, listens on port 16'h1F90
  logic [31:0] b_s_tdata = '0;
  logic [3:0]  b_s_tkeep = '0;
  logic        b_s_tvalid = 1'b0, b_s_tlast = 1'b0, b_s_tready;
  logic [31:0] b_m_tdata;
  logic [3:0]  b_m_tkeep;
  logic        b_m_tvalid, b_m_tlast, b_m_tuser;
  logic        b_m_tready = 1'b1;
  logic [15:0] b_src, b_dest, b_len;
  logic        b_hdr_valid;
  logic [31:0] b_st_ok, b_st_drop, b_st_err;

  udp_rx_strip #(.DATA_BYTES(1), .LISTEN_PORT(16'h0000)) u_a (
    .clk(clk), .reset_n(reset_n),
    .s_tdata(a_s_tdata), .s_tkeep(a_s_tkeep), .s_tvalid(a_s_tvalid), .s_tlast(a_s_tlast),
    .s_tready(a_s_tready),
    .m_tdata(a_m_tdata), .m_tkeep(a_m_tkeep), .m_tvalid(a_m_tvalid), .m_tlast(a_m_tlast),
    .m_tuser(a_m_tuser), .m_tready(a_m_tready),
    .src_port_out(a_src), .dest_port_out(a_dest), .length_out(a_len),
    .hdr_valid_out(a_hdr_valid),
    .stat_ok_out(a_st_ok), .stat_drop_out(a_st_drop), .stat_err_out(a_st_err)
  );

  udp_rx_strip #(.DATA_BYTES(4), .LISTEN_PORT(16'h1F90)) u_b (
    .clk(clk), .reset_n(reset_n),
    .s_tdata(b_s_tdata), .s_tkeep(b_s_tkeep), .s_tvalid(b_s_tvalid), .s_tlast(b_s_tlast),
    .s_tready(b_s_tready),
    .m_tdata(b_m_tdata), .m_tkeep(b_m_tkeep), .m_tvalid(b_m_tvalid), .m_tlast(b_m_tlast),
    .m_tuser(b_m_tuser), .m_tready(b_m_tready),
    .src_port_out(b_src), .dest_port_out(b_dest), .length_out(b_len),
    .hdr_valid_out(b_hdr_valid),
    .stat_ok_out(b_st_ok), .stat_drop_out(b_st_drop), .stat_err_out(b_st_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  function automatic byte_q_t hdr(input logic [15:0] src, input logic [15:0] dst,
                                  input logic [15:0] len);
    byte_q_t q;
    q = '{src[15:8], src[7:0], dst[15:8], dst[7:0], len[15:8], len[7:0], 8'h00, 8'h00};
    return q;
  endfunction

  // Output-side monitors, sampled on the falling edge
  logic [8:0] a_out [$];
  logic       a_last_user;
  int         a_hdr_cnt = 0, a_stall_seen = 0, a_stall_viol = 0;
  logic       a_prev_stall = 1'b0, a_prev_last = 1'b0;
  logic [7:0] a_prev_data = '0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (a_prev_stall) begin
        a_stall_seen++;
        if (!a_m_tvalid || a_m_tdata !== a_prev_data || a_m_tlast !== a_prev_last) a_stall_viol++;
      end
      if (a_m_tvalid && a_m_tready) begin
        a_out.push_back({a_m_tlast, a_m_tdata});
        if (a_m_tlast) a_last_user = a_m_tuser;
      end
      a_prev_stall = a_m_tvalid && !a_m_tready;
      a_prev_data  = a_m_tdata;
      a_prev_last  = a_m_tlast;
      if (a_hdr_valid) a_hdr_cnt++;
    end else begin
      a_prev_stall = 1'b0;
    end
  end

  logic [7:0] b_bytes [$];
  logic [3:0] b_last_keep;
  logic       b_last_user;
  int         b_hdr_cnt = 0, b_valid_seen = 0, b_notready = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (b_m_tvalid) b_valid_seen++;
      if (!b_s_tready) b_notready++;
      if (b_hdr_valid) b_hdr_cnt++;
      if (b_m_tvalid && b_m_tready) begin
        for (int l = 0; l < 4; l++) if (b_m_tkeep[l]) b_bytes.push_back(b_m_tdata[8*l +: 8]);
        if (b_m_tlast) begin
          b_last_keep = b_m_tkeep;
          b_last_user = b_m_tuser;
        end
      end
    end
  end

  // Cycle stepping; A's m_tready follows the 1,0,0,1 pattern while stall mode is on
  int         cyc = 0;
  logic       a_stall_mode = 1'b0;
  logic [3:0] stall_pat = 4'b1001;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    a_m_tready = a_stall_mode ? stall_pat[cyc % 4] : 1'b1;
  endtask

  task automatic send_a(input byte_q_t bytes, input int n_beats);
    int   i = 0;
    int   guard = 0;
    logic rdy;
    while (i < n_beats && guard < 2000) begin
      a_s_tvalid = 1'b1;
      a_s_tdata  = bytes[i];
      a_s_tlast  = (i == bytes.size() - 1);
      #1;
      rdy = a_s_tready;
      tick();
      if (rdy) i++;
      guard++;
    end
    a_s_tvalid = 1'b0;
    a_s_tlast  = 1'b0;
    check("a_send_complete", 64'(i), 64'(n_beats));
  endtask

  task automatic send_b(input byte_q_t bytes);
    int   i = 0;
    int   guard = 0;
    int   n = bytes.size();
    logic rdy;
    while (i < n && guard < 2000) begin
      b_s_tdata = '0;
      b_s_tkeep = '0;
      for (int l = 0; l < 4; l++) begin
        if (i + l < n) begin
          b_s_tdata[8*l +: 8] = bytes[i + l];
          b_s_tkeep[l] = 1'b1;
        end
      end
      b_s_tlast  = (i + 4 >= n);
      b_s_tvalid = 1'b1;
      #1;
      rdy = b_s_tready;
      tick();
      if (rdy) i += 4;
      guard++;
    end
    b_s_tvalid = 1'b0;
    b_s_tlast  = 1'b0;
    check("b_send_complete", 64'(i >= n), 64'(1));
  endtask

  initial begin
    byte_q_t    f;
    byte_q_t    pl;
    logic [8:0] exp9;

    // Reset state
    repeat (2) tick();
    check("rst_s_tready", a_s_tready, 0);
    check("rst_m_tvalid", a_m_tvalid, 0);
    check("rst_hdr_valid", a_hdr_valid, 0);
    check("rst_src", a_src, 0);
    check("rst_len", a_len, 0);
    check("rst_stat_ok", a_st_ok, 0);
    reset_n = 1'b1;
    tick();
    #1;
    check("hdr_s_tready", a_s_tready, 1);

    // Basic 1-byte frame
    pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    f = hdr(16'h1234, 16'h0050, 16'h000C);
    foreach (pl[k]) f.push_back(pl[k]);
    send_a(f, f.size());
    repeat (4) tick();
    check("t1_hdr_pulses", a_hdr_cnt, 1);
    check("t1_src", a_src, 16'h1234);
    check("t1_dest", a_dest, 16'h0050);
    check("t1_len", a_len, 16'h000C);
    check("t1_beats", a_out.size(), 4);
    for (int k = 0; k < 4; k++) begin
      exp9 = {(k == 3) ? 1'b1 : 1'b0, pl[k]};
      check($sformatf("t1_beat%0d", k), a_out[k], exp9);
    end
    check("t1_tuser", a_last_user, 0);
    check("t1_stat_ok", a_st_ok, st(1));
    a_out.delete();

    // Runt frame immediately followed by a valid frame
    f = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_a(f, f.size());
    f = hdr(16'h5555, 16'h0050, 16'h000A);
    f.push_back(8'h11);
    f.push_back(8'h22);
    send_a(f, f.size());
    repeat (4) tick();
    check("t2_hdr_pulses", a_hdr_cnt, 2);
    check("t2_src", a_src, 16'h5555);
    check("t2_len", a_len, 16'h000A);
    check("t2_beats", a_out.size(), 2);
    check("t2_beat0", a_out[0], {1'b0, 8'h11});
    check("t2_beat1", a_out[1], {1'b1, 8'h22});
    check("t2_tuser", a_last_user, 0);
    check("t2_stat_drop", a_st_drop, st(1));
    check("t2_stat_ok", a_st_ok, st(2));
    a_out.delete();

    // 64-byte payload under a 1,0,0,1 m_tready pattern
    pl.delete();
    for (int k = 0; k < 64; k++) pl.push_back(8'(k * 3 + 1));
    f = hdr(16'h0007, 16'h0050, 16'h0048);
    foreach (pl[k]) f.push_back(pl[k]);
    a_stall_mode = 1'b1;
    send_a(f, f.size());
    repeat (20) tick();
    a_stall_mode = 1'b0;
    tick();
    check("t3_beats", a_out.size(), 64);
    for (int k = 0; k < 64; k++) begin
      exp9 = {(k == 63) ? 1'b1 : 1'b0, pl[k]};
      check($sformatf("t3_beat%0d", k), a_out[k], exp9);
    end
    check("t3_tuser", a_last_user, 0);
    check("t3_stalls_seen", a_stall_seen > 0, 1);
    check("t3_stall_stable", a_stall_viol, 0);
    check("t3_stat_ok", a_st_ok, st(3));
    a_out.delete();

    // Instance B: filtered-out frame, then passing frames with length checks
    f = hdr(16'h0001, 16'h0050, 16'h0012);
    for (int k = 0; k < 10; k++) f.push_back(8'(8'h40 + k));
    send_b(f);
    repeat (3) tick();
    check("t4_no_tvalid", b_valid_seen, 0);
    check("t4_no_hdr", b_hdr_cnt, 0);
    check("t4_ready_held", b_notready, 0);
    check("t4_stat_drop", b_st_drop, st(1));

    pl = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27};
    f = hdr(16'h0001, 16'h1F90, 16'h000F);
    foreach (pl[k]) f.push_back(pl[k]);
    send_b(f);
    repeat (3) tick();
    check("t5_hdr_pulses", b_hdr_cnt, 1);
    check("t5_dest", b_dest, 16'h1F90);
    check("t5_len", b_len, 16'h000F);
    check("t5_bytes", b_bytes.size(), 7);
    for (int k = 0; k < 7; k++) check($sformatf("t5_byte%0d", k), b_bytes[k], pl[k]);
    check("t5_last_keep", b_last_keep, 4'h7);
    check("t5_tuser", b_last_user, 0);
    check("t5_stat_ok", b_st_ok, st(1));
    b_bytes.delete();

    f = hdr(16'h0001, 16'h1F90, 16'h0010);
    foreach (pl[k]) f.push_back(pl[k]);
    send_b(f);
    repeat (3) tick();
    check("t6_bytes", b_bytes.size(), 7);
    check("t6_last_keep", b_last_keep, 4'h7);
    check("t6_tuser", b_last_user, 1);
    check("t6_stat_err", b_st_err, st(1));
    check("t6_stat_ok", b_st_ok, st(1));
    b_bytes.delete();

    // Header-only frame: accepted with no payload
    f = hdr(16'hBEEF, 16'h1F90, 16'h0008);
    send_b(f);
    repeat (3) tick();
    check("t7_hdr_pulses", b_hdr_cnt, 3);
    check("t7_src", b_src, 16'hBEEF);
    check("t7_no_payload", b_bytes.size(), 0);
    check("t7_stat_ok", b_st_ok, st(2));

    // Reset asserted mid-payload
    f = hdr(16'h00AB, 16'h0050, 16'h000C);
    f.push_back(8'hAA); f.push_back(8'hBB); f.push_back(8'hCC); f.push_back(8'hDD);
    send_a(f, 10);
    check("t8_pre_tvalid", a_m_tvalid, 1);
    check("t8_pre_src", a_src, 16'h00AB);
    reset_n = 1'b0;
    #1;
    check("t8_rst_tvalid", a_m_tvalid, 0);
    check("t8_rst_tdata", a_m_tdata, 0);
    check("t8_rst_tlast", a_m_tlast, 0);
    check("t8_rst_src", a_src, 0);
    check("t8_rst_len", a_len, 0);
    check("t8_rst_s_tready", a_s_tready, 0);
    check("t8_rst_stat_ok", a_st_ok, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    a_out.delete();
    a_hdr_cnt = 0;
    tick();
    f = hdr(16'h0CDE, 16'h0050, 16'h000A);
    f.push_back(8'h77);
    f.push_back(8'h88);
    send_a(f, f.size());
    repeat (4) tick();
    check("t9_hdr_pulses", a_hdr_cnt, 1);
    check("t9_src", a_src, 16'h0CDE);
    check("t9_beats", a_out.size(), 2);
    check("t9_beat0", a_out[0], {1'b0, 8'h77});
    check("t9_beat1", a_out[1], {1'b1, 8'h88});
    check("t9_tuser", a_last_user, 0);
    check("t9_stat_ok", a_st_ok, st(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
